cpu_bus_resp: RTL and testbench
===============================

CPU_BUS_RESP -- requirements
Module: cpu_bus_resp

Interface
REQ-001 Parameter MEM_TIMEOUT, default 4: maximum cycles a memory request may wait for mem_ready before an error is flagged.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_cycle  input  1  reset, synchronous, active-high.
REQ-004 state  input  8  control-state code from the CPU control FSM.
REQ-005 addr_in  input  8  address bus (PC/SP/register value) for the current state.
REQ-006 data_in  input  8  write data / OUT data from the register file.
REQ-007 instruction  output  8  fetched instruction byte, registered.
REQ-008 data_out  output  8  read or IN data byte, registered.
REQ-009 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-010 mem_addr, mem_wdata  output  8 each  external RAM address / write data.
REQ-011 mem_rd, mem_wr  output  1 each  RAM read / write request, level, held until mem_ready.
REQ-012 mem_rdata  input  8  RAM read data, sampled when mem_ready=1.
REQ-013 mem_ready  input  1  RAM completion for the outstanding request.
REQ-014 io_port  output  8  latched IO port number.
REQ-015 io_out_data, io_out_valid / io_out_ready  output 8, output 1 / input 1  OUT handshake.
REQ-016 io_in_data, io_in_valid / io_in_ready  input 8, input 1 / output 1  IN handshake.
REQ-017 busy  output  1  high whenever the bus FSM is not IDLE.
REQ-018 bus_err  output  1  sticky protocol/timeout error.

Function
REQ-019 State decode uses shared codes: FETCH_PC 0x01, FETCH_INST 0x02, HALT 0x03, OUT 0x05, MOV_STORE 0x08, MOV_FETCH 0x09, MOV_LOAD 0x0A, FETCH_SP 0x0C, PC_STORE 0x0D, RET 0x0F, SET_ADDR 0x11, IN 0x12, REG_STORE 0x13, SET_REG 0x14, LOAD_IMM 0x15, WAIT_FOR_RAM 0x16; all other codes take no action.
REQ-020 Bus FSM states: IDLE, READ, WRITE, IO_OUT, IO_IN; one transaction outstanding at a time.
REQ-021 Address states (FETCH_PC, FETCH_SP, MOV_FETCH) in IDLE: mar<=addr_in, rbuf_valid<=0, go READ with mem_rd=1, mem_addr=mar from the next cycle.
REQ-022 READ: on mem_ready, rbuf<=mem_rdata, rbuf_valid<=1, mem_rd<=0, go IDLE in the same edge.
REQ-023 Consumer states: FETCH_INST loads instruction<=rbuf; MOV_LOAD, LOAD_IMM, RET, SET_REG load data_out<=rbuf and pulse data_valid, one cycle after the state is seen.
REQ-024 Consumer state with rbuf_valid=0 (incl. while READ) sets bus_err; instruction/data_out unchanged.
REQ-025 Store states (MOV_STORE, REG_STORE, PC_STORE) in IDLE: mem_addr<=mar, mem_wdata<=data_in, go WRITE with mem_wr=1 until mem_ready, then IDLE.
REQ-026 SET_ADDR: io_port<=addr_in. OUT: io_out_data<=data_in, go IO_OUT with io_out_valid=1 until io_out_ready, then IDLE. IN: go IO_IN with io_in_ready=1 until io_in_valid; then data_out<=io_in_data, data_valid pulse, IDLE.
REQ-027 Any address/store/IO state arriving while not IDLE sets bus_err and is dropped; the outstanding transaction continues.
REQ-028 READ or WRITE lasting MEM_TIMEOUT cycles without mem_ready: deassert request, set bus_err, go IDLE; IO waits have no timeout.
REQ-029 WAIT_FOR_RAM and HALT take no action; HALT does not abort an outstanding transaction.
REQ-030 mem_ready in the same cycle as the timeout limit counts as completion, no error.

Reset
REQ-031 reset_cycle=1 at a rising edge: FSM IDLE; mar, rbuf, instruction, data_out, io_port, io_out_data, mem_addr, mem_wdata <= 0x00; rbuf_valid, mem_rd, mem_wr, io_out_valid, io_in_ready, data_valid, busy, bus_err <= 0.
REQ-032 Reset mid-transaction drops the request the following cycle with no completion.

Structure
REQ-033 State codes and bus-FSM enum live in shared package cpu_pkg, also used by cpu_ctrl.
REQ-034 Single module; timeout counter is 3 bits wide minimum, sized from MEM_TIMEOUT.

Verification
REQ-035 FETCH_PC addr_in=0x10, RAM ready after 1 wait, rdata=0x81, then FETCH_INST -> mem_addr=0x10, instruction=0x81, bus_err=0.
REQ-036 MOV_FETCH addr_in=0x40, rdata=0x5A, then MOV_LOAD -> data_out=0x5A with one data_valid pulse.
REQ-037 FETCH_SP addr_in=0xFE, REG_STORE data_in=0x33 -> mem_wr=1, mem_addr=0xFE, mem_wdata=0x33 until mem_ready.
REQ-038 SET_ADDR 0x02, OUT data_in=0x7E, io_out_ready after 3 cycles -> io_port=0x02, io_out_data=0x7E, busy 3 cycles; IN with io_in_data=0xC4 -> data_out=0xC4.
REQ-039 FETCH_PC with mem_ready never asserted -> mem_rd drops after 4 cycles, bus_err=1; FETCH_INST before ready -> bus_err=1.
REQ-040 reset_cycle during WRITE -> mem_wr=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-state codes driven by cpu_ctrl and the
// bus-response FSM encoding, plus state-class decode helpers.
package cpu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned STATE_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH_PC     = 8'h01,
      ST_FETCH_INST   = 8'h02,
      ST_HALT         = 8'h03,
      ST_OUT          = 8'h05,
      ST_MOV_STORE    = 8'h08,
      ST_MOV_FETCH    = 8'h09,
      ST_MOV_LOAD     = 8'h0A,
      ST_FETCH_SP     = 8'h0C,
      ST_PC_STORE     = 8'h0D,
      ST_RET          = 8'h0F,
      ST_SET_ADDR     = 8'h11,
      ST_IN           = 8'h12,
      ST_REG_STORE    = 8'h13,
      ST_SET_REG      = 8'h14,
      ST_LOAD_IMM     = 8'h15,
      ST_WAIT_FOR_RAM = 8'h16
   } ctrl_state_e;

   typedef enum logic [2:0] {
      BUS_IDLE   = 3'd0,
      BUS_READ   = 3'd1,
      BUS_WRITE  = 3'd2,
      BUS_IO_OUT = 3'd3,
      BUS_IO_IN  = 3'd4
   } bus_state_e;

   // States that present an address and start a RAM read.
   function automatic logic is_addr_state(input logic [STATE_W-1:0] s);
      return (s == ST_FETCH_PC) || (s == ST_FETCH_SP) || (s == ST_MOV_FETCH);
   endfunction

   function automatic logic is_store_state(input logic [STATE_W-1:0] s);
      return (s == ST_MOV_STORE) || (s == ST_REG_STORE) || (s == ST_PC_STORE);
   endfunction

   // States that consume the byte captured by the last completed read.
   function automatic logic is_consumer_state(input logic [STATE_W-1:0] s);
      return (s == ST_FETCH_INST) || (s == ST_MOV_LOAD) || (s == ST_LOAD_IMM) ||
             (s == ST_RET) || (s == ST_SET_REG);
   endfunction

endpackage

// File: rtl/cpu_bus_resp.sv
// Bus responder for the CPU control FSM: turns control-state codes into RAM
// read/write requests and IO port handshakes, one transaction at a time.
module cpu_bus_resp
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 4
)
(
   input  logic              clk,
   input  logic              reset_cycle,
   input  logic [STATE_W-1:0] state,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] instruction,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] io_port,
   output logic [DATA_W-1:0] io_out_data,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   input  logic [DATA_W-1:0] io_in_data,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   output logic              busy,
   output logic              bus_err
);

   localparam int unsigned CNT_W = ($clog2(MEM_TIMEOUT + 1) > 3) ? $clog2(MEM_TIMEOUT + 1) : 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   bus_state_e        r_fsm;
   logic [CNT_W-1:0]  r_tmo_cnt;
   logic [DATA_W-1:0] r_mar;
   logic [DATA_W-1:0] r_rbuf;
   logic              r_rbuf_valid;
   logic [DATA_W-1:0] r_instruction;
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_valid;
   logic [DATA_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_io_port;
   logic [DATA_W-1:0] r_io_out_data;
   logic              r_io_out_valid;
   logic              r_io_in_ready;
   logic              r_busy;
   logic              r_bus_err;

   logic w_addr;
   logic w_store;
   logic w_out;
   logic w_in;
   logic w_start;
   logic w_consumer;
   logic w_fetch_inst;
   logic w_set_addr;

   // Control-state decode.
   assign w_addr       = is_addr_state(state);
   assign w_store      = is_store_state(state);
   assign w_out        = (state == ST_OUT);
   assign w_in         = (state == ST_IN);
   assign w_start      = w_addr | w_store | w_out | w_in;
   assign w_consumer   = is_consumer_state(state);
   assign w_fetch_inst = (state == ST_FETCH_INST);
   assign w_set_addr   = (state == ST_SET_ADDR);

   always_ff @(posedge clk) begin
      if (reset_cycle) begin
         r_fsm          <= BUS_IDLE;
         r_tmo_cnt      <= '0;
         r_mar          <= '0;
         r_rbuf         <= '0;
         r_rbuf_valid   <= 1'b0;
         r_instruction  <= '0;
         r_data_out     <= '0;
         r_data_valid   <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_mem_rd       <= 1'b0;
         r_mem_wr       <= 1'b0;
         r_io_port      <= '0;
         r_io_out_data  <= '0;
         r_io_out_valid <= 1'b0;
         r_io_in_ready  <= 1'b0;
         r_busy         <= 1'b0;
         r_bus_err      <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;

         // Consumers take the read buffer; an empty buffer is a sequencing error.
         if (w_consumer) begin
            if (!r_rbuf_valid) begin
               r_bus_err <= 1'b1;
            end else if (w_fetch_inst) begin
               r_instruction <= r_rbuf;
            end else begin
               r_data_out   <= r_rbuf;
               r_data_valid <= 1'b1;
            end
         end

         if (w_set_addr) begin
            r_io_port <= addr_in;
         end

         // New transactions only start from IDLE; otherwise they are dropped.
         if (w_start) begin
            if (r_fsm != BUS_IDLE) begin
               r_bus_err <= 1'b1;
            end else if (w_addr) begin
               r_mar        <= addr_in;
               r_mem_addr   <= addr_in;
               r_rbuf_valid <= 1'b0;
               r_mem_rd     <= 1'b1;
               r_tmo_cnt    <= '0;
               r_busy       <= 1'b1;
               r_fsm        <= BUS_READ;
            end else if (w_store) begin
               r_mem_addr  <= r_mar;
               r_mem_wdata <= data_in;
               r_mem_wr    <= 1'b1;
               r_tmo_cnt   <= '0;
               r_busy      <= 1'b1;
               r_fsm       <= BUS_WRITE;
            end else if (w_out) begin
               r_io_out_data  <= data_in;
               r_io_out_valid <= 1'b1;
               r_busy         <= 1'b1;
               r_fsm          <= BUS_IO_OUT;
            end else begin
               r_io_in_ready <= 1'b1;
               r_busy        <= 1'b1;
               r_fsm         <= BUS_IO_IN;
            end
         end

         // Completion of the outstanding transaction; ready on the last cycle wins over timeout.
         case (r_fsm)
            BUS_IDLE: ;
            BUS_READ: begin
               if (mem_ready) begin
                  r_rbuf       <= mem_rdata;
                  r_rbuf_valid <= 1'b1;
                  r_mem_rd     <= 1'b0;
                  r_busy       <= 1'b0;
                  r_fsm        <= BUS_IDLE;
               end else if (r_tmo_cnt == CNT_LAST) begin
                  r_mem_rd  <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_busy    <= 1'b0;
                  r_fsm     <= BUS_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
               end
            end
            BUS_WRITE: begin
               if (mem_ready) begin
                  r_mem_wr <= 1'b0;
                  r_busy   <= 1'b0;
                  r_fsm    <= BUS_IDLE;
               end else if (r_tmo_cnt == CNT_LAST) begin
                  r_mem_wr  <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_busy    <= 1'b0;
                  r_fsm     <= BUS_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
               end
            end
            BUS_IO_OUT: begin
               if (io_out_ready) begin
                  r_io_out_valid <= 1'b0;
                  r_busy         <= 1'b0;
                  r_fsm          <= BUS_IDLE;
               end
            end
            BUS_IO_IN: begin
               if (io_in_valid) begin
                  r_data_out    <= io_in_data;
                  r_data_valid  <= 1'b1;
                  r_io_in_ready <= 1'b0;
                  r_busy        <= 1'b0;
                  r_fsm         <= BUS_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign instruction  = r_instruction;
   assign data_out     = r_data_out;
   assign data_valid   = r_data_valid;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_rd       = r_mem_rd;
   assign mem_wr       = r_mem_wr;
   assign io_port      = r_io_port;
   assign io_out_data  = r_io_out_data;
   assign io_out_valid = r_io_out_valid;
   assign io_in_ready  = r_io_in_ready;
   assign busy         = r_busy;
   assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_cpu_bus_resp.sv
// Self-checking bench for cpu_bus_resp: directed vector table, hand sequences
// for timeout/collision/reset corners, then random traffic against a model.
module tb_cpu_bus_resp;

   localparam int unsigned TMO = 4;
   localparam int P_NONE = 0;
   localparam int P_RD   = 1;
   localparam int P_WR   = 2;
   localparam int P_OUT  = 3;
   localparam int P_IN   = 4;

   logic       clk = 1'b0;
   logic       reset_cycle;
   logic [7:0] state, addr_in, data_in, mem_rdata, io_in_data;
   logic       mem_ready, io_out_ready, io_in_valid;
   logic [7:0] instruction, data_out, mem_addr, mem_wdata, io_port, io_out_data;
   logic       data_valid, mem_rd, mem_wr, io_out_valid, io_in_ready, busy, bus_err;

   cpu_bus_resp #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_cycle(reset_cycle), .state(state), .addr_in(addr_in),
      .data_in(data_in), .instruction(instruction), .data_out(data_out),
      .data_valid(data_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .io_port(io_port), .io_out_data(io_out_data), .io_out_valid(io_out_valid),
      .io_out_ready(io_out_ready), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
      .io_in_ready(io_in_ready), .busy(busy), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] instr;
      logic [7:0] dout;
      logic       dv;
      logic [7:0] maddr;
      logic [7:0] mwd;
      logic       mrd;
      logic       mwr;
      logic [7:0] ioport;
      logic [7:0] iod;
      logic       iov;
      logic       iir;
      logic       busy;
      logic       err;
   } out_t;

   typedef struct {
      logic [7:0] st, a, d, rdata;
      logic       rdy, ordy;
      logic [7:0] idata;
      logic       ivld;
      out_t       exp;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending transaction kind, cycles waited, read buffer.
   int         m_pend, m_wait;
   logic [7:0] m_buf, m_mar;
   logic       m_ok;
   out_t       m_o;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_out(input string tag, input out_t e);
      chk({tag, " instruction"}, instruction, e.instr);
      chk({tag, " data_out"}, data_out, e.dout);
      chk({tag, " data_valid"}, 8'(data_valid), 8'(e.dv));
      chk({tag, " mem_addr"}, mem_addr, e.maddr);
      chk({tag, " mem_wdata"}, mem_wdata, e.mwd);
      chk({tag, " mem_rd"}, 8'(mem_rd), 8'(e.mrd));
      chk({tag, " mem_wr"}, 8'(mem_wr), 8'(e.mwr));
      chk({tag, " io_port"}, io_port, e.ioport);
      chk({tag, " io_out_data"}, io_out_data, e.iod);
      chk({tag, " io_out_valid"}, 8'(io_out_valid), 8'(e.iov));
      chk({tag, " io_in_ready"}, 8'(io_in_ready), 8'(e.iir));
      chk({tag, " busy"}, 8'(busy), 8'(e.busy));
      chk({tag, " bus_err"}, 8'(bus_err), 8'(e.err));
   endtask

   function automatic out_t o(input logic [7:0] instr, input logic [7:0] dout, input logic dv,
                              input logic [7:0] maddr, input logic [7:0] mwd, input logic mrd,
                              input logic mwr, input logic [7:0] ioport, input logic [7:0] iod,
                              input logic iov, input logic iir, input logic bsy, input logic err);
      out_t r;
      r.instr = instr; r.dout = dout; r.dv = dv; r.maddr = maddr; r.mwd = mwd;
      r.mrd = mrd; r.mwr = mwr; r.ioport = ioport; r.iod = iod; r.iov = iov;
      r.iir = iir; r.busy = bsy; r.err = err;
      return r;
   endfunction

   function automatic vec_t v(input logic [7:0] st, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] rdata, input logic rdy, input logic ordy,
                              input logic [7:0] idata, input logic ivld, input out_t e);
      vec_t r;
      r.st = st; r.a = a; r.d = d; r.rdata = rdata; r.rdy = rdy; r.ordy = ordy;
      r.idata = idata; r.ivld = ivld; r.exp = e;
      return r;
   endfunction

   task automatic drive(input logic [7:0] st, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rdata, input logic rdy, input logic ordy,
                        input logic [7:0] idata, input logic ivld);
      state = st; addr_in = a; data_in = d; mem_rdata = rdata; mem_ready = rdy;
      io_out_ready = ordy; io_in_data = idata; io_in_valid = ivld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_cycle = 1'b1;
      drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      reset_cycle = 1'b0;
   endtask

   task automatic model_reset();
      m_pend = P_NONE; m_wait = 0; m_buf = 8'h00; m_mar = 8'h00; m_ok = 1'b0; m_o = '0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_step();
      int         p;
      logic       ok;
      logic [7:0] b;
      if (reset_cycle) begin
         model_reset();
         return;
      end
      p = m_pend; ok = m_ok; b = m_buf;
      m_o.dv = 1'b0;
      if (state inside {8'h02, 8'h0A, 8'h15, 8'h0F, 8'h14}) begin
         if (!ok) m_o.err = 1'b1;
         else if (state == 8'h02) m_o.instr = b;
         else begin m_o.dout = b; m_o.dv = 1'b1; end
      end
      if (state == 8'h11) m_o.ioport = addr_in;
      if (state inside {8'h01, 8'h0C, 8'h09, 8'h08, 8'h13, 8'h0D, 8'h05, 8'h12}) begin
         if (p != P_NONE) m_o.err = 1'b1;
         else if (state inside {8'h01, 8'h0C, 8'h09}) begin
            m_mar = addr_in; m_o.maddr = addr_in; m_ok = 1'b0; m_pend = P_RD; m_wait = 0;
         end else if (state inside {8'h08, 8'h13, 8'h0D}) begin
            m_o.maddr = m_mar; m_o.mwd = data_in; m_pend = P_WR; m_wait = 0;
         end else if (state == 8'h05) begin
            m_o.iod = data_in; m_pend = P_OUT;
         end else begin
            m_pend = P_IN;
         end
      end
      if (p == P_RD || p == P_WR) begin
         if (mem_ready) begin
            if (p == P_RD) begin m_buf = mem_rdata; m_ok = 1'b1; end
            m_pend = P_NONE;
         end else if (m_wait + 1 >= int'(TMO)) begin
            m_pend = P_NONE; m_o.err = 1'b1;
         end else begin
            m_wait++;
         end
      end else if (p == P_OUT) begin
         if (io_out_ready) m_pend = P_NONE;
      end else if (p == P_IN) begin
         if (io_in_valid) begin
            m_o.dout = io_in_data; m_o.dv = 1'b1; m_pend = P_NONE;
         end
      end
   endtask

   function automatic out_t model_out();
      out_t e;
      e      = m_o;
      e.mrd  = (m_pend == P_RD);
      e.mwr  = (m_pend == P_WR);
      e.iov  = (m_pend == P_OUT);
      e.iir  = (m_pend == P_IN);
      e.busy = (m_pend != P_NONE);
      return e;
   endfunction

   vec_t vec[21];
   logic [7:0] codes[18];

   initial begin
      reset_cycle = 1'b1;
      drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      cmp_out("reset", '0);
      reset_cycle = 1'b0;

      vec[0]  = v(8'h01, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[1]  = v(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[2]  = v(8'h16, 8'h00, 8'h00, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, o(8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[3]  = v(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[4]  = v(8'h09, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[5]  = v(8'h16, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[6]  = v(8'h0A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[7]  = v(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[8]  = v(8'h0C, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[9]  = v(8'h16, 8'h00, 8'h00, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[10] = v(8'h13, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[11] = v(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec[12] = v(8'h16, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[13] = v(8'h11, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[14] = v(8'h05, 8'h00, 8'h7E, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0));
      vec[15] = v(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0));
      vec[16] = v(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0));
      vec[17] = v(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[18] = v(8'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h5A, 1'b0, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0));
      vec[19] = v(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'hC4, 1'b1, o(8'h81, 8'hC4, 1'b1, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));
      vec[20] = v(8'h0F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, o(8'h81, 8'h11, 1'b1, 8'hFE, 8'h33, 1'b0, 1'b0, 8'h02, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < 21; i++) begin
         drive(vec[i].st, vec[i].a, vec[i].d, vec[i].rdata, vec[i].rdy, vec[i].ordy,
               vec[i].idata, vec[i].ivld);
         tick();
         cmp_out($sformatf("vec%0d", i), vec[i].exp);
      end

      // Read that never completes: four request cycles, then error.
      do_reset();
      drive(8'h01, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("tmo mem_rd c1", 8'(mem_rd), 8'h01);
      for (int k = 0; k < 3; k++) begin
         drive(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
         tick();
         chk($sformatf("tmo mem_rd c%0d", k + 2), 8'(mem_rd), 8'h01);
         chk($sformatf("tmo bus_err c%0d", k + 2), 8'(bus_err), 8'h00);
      end
      tick();
      chk("tmo mem_rd drop", 8'(mem_rd), 8'h00);
      chk("tmo bus_err", 8'(bus_err), 8'h01);
      chk("tmo busy", 8'(busy), 8'h00);

      // Ready on the last allowed cycle is a normal completion.
      do_reset();
      drive(8'h01, 8'h21, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      drive(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick(); tick(); tick();
      drive(8'h16, 8'h00, 8'h00, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("edge mem_rd", 8'(mem_rd), 8'h00);
      chk("edge bus_err", 8'(bus_err), 8'h00);
      drive(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("edge instruction", instruction, 8'h99);
      chk("edge bus_err after fetch", 8'(bus_err), 8'h00);

      // Consumer while the read is still outstanding.
      do_reset();
      drive(8'h01, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      drive(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("early fetch bus_err", 8'(bus_err), 8'h01);
      chk("early fetch instruction", instruction, 8'h00);
      chk("early fetch mem_rd", 8'(mem_rd), 8'h01);

      // Store arriving during a read is dropped; the read still completes.
      do_reset();
      drive(8'h09, 8'h23, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      drive(8'h08, 8'h00, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("collide bus_err", 8'(bus_err), 8'h01);
      chk("collide mem_wr", 8'(mem_wr), 8'h00);
      chk("collide mem_wdata", mem_wdata, 8'h00);
      chk("collide mem_rd", 8'(mem_rd), 8'h01);
      drive(8'h16, 8'h00, 8'h00, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("collide read done", 8'(mem_rd), 8'h00);
      drive(8'h15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("collide data_out", data_out, 8'h77);

      // Reset in the middle of a write.
      do_reset();
      drive(8'h0C, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      drive(8'h16, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      drive(8'h13, 8'h00, 8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("wr mem_wr", 8'(mem_wr), 8'h01);
      chk("wr mem_addr", mem_addr, 8'h30);
      chk("wr mem_wdata", mem_wdata, 8'h44);
      reset_cycle = 1'b1;
      drive(8'h16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      cmp_out("rst_wr", '0);
      reset_cycle = 1'b0;
      tick();
      chk("rst_wr after mem_wr", 8'(mem_wr), 8'h00);
      chk("rst_wr after busy", 8'(busy), 8'h00);

      // Random traffic against the model.
      codes = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h09, 8'h0A, 8'h0C, 8'h0D,
                8'h0F, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h00, 8'h00};
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         int         idx;
         logic [7:0] st;
         idx = int'($urandom_range(0, 19));
         if (idx >= 18) st = 8'($urandom);
         else st = codes[idx];
         reset_cycle = ($urandom_range(0, 99) == 0);
         drive(st, 8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0),
               8'($urandom), ($urandom_range(0, 3) == 0));
         model_step();
         tick();
         cmp_out($sformatf("rand%0d", n), model_out());
      end
      reset_cycle = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
